// File: rtl/reaction_pkg.sv
// reaction_pkg
// Shared definitions for the reaction-timer game: the delay FSM state
// encoding, the LFSR feedback taps and the default seed / minimum hold.
// No ports; imported by the game's RTL modules.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } delay_state_t;

    // Feedback taps for x^7 + x^3 + 1: bits 6 and 2 of the shift register.
    localparam logic [6:0] LFSR_TAPS = 7'b100_0100;

    localparam logic [6:0] DEFAULT_SEED      = 7'h01;
    localparam int         DEFAULT_MIN_TICKS = 250;

endpackage

// File: rtl/lfsr7.sv
// lfsr7
// 7-bit Fibonacci LFSR (x^7 + x^3 + 1), shifting left, period 127.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, loads SEED
//   en   - advance one step per clk while high
//   q    - current LFSR value
module lfsr7
    import reaction_pkg::*;
#(
    parameter logic [6:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] q
);

    // SEED must be non-zero: the all-zero state would lock the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[5:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/random_delay.sv
// random_delay
// Random hold period for the reaction-timer game. On a rising edge of
// start_delay it loads MIN_TICKS + lfsr into a down-counter, counts it down
// on the 1 ms tick enable and then emits a one-clk time_out pulse.
// Ports:
//   clk          - system clock
//   rst          - asynchronous active-high reset
//   tick         - one-clk enable pulse per ms
//   en_lfsr      - advance the LFSR one step per clk while high
//   start_delay  - level from the sequencer; rising edge starts a delay
//   time_out     - one-clk pulse when the delay expires
//   busy         - high while counting
//   delay_ticks  - last loaded delay value, held for display
module random_delay
    import reaction_pkg::*;
#(
    parameter int               LFSR_W    = 7,
    parameter int               CNT_W     = 16,
    parameter int               MIN_TICKS = DEFAULT_MIN_TICKS,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en_lfsr,
    input  logic             start_delay,
    output logic             time_out,
    output logic             busy,
    output logic [CNT_W-1:0] delay_ticks
);

    // The LFSR sub-module is fixed at 7 bits, so LFSR_W is expected to be 7.
    logic [LFSR_W-1:0] lfsr;
    logic              start_q;
    logic              start_rise;
    delay_state_t      state;
    delay_state_t      next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  load_value;
    logic              load;
    logic              decrement;
    logic              expire;

    lfsr7 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (en_lfsr),
        .q   (lfsr)
    );

    assign start_rise = start_delay & ~start_q;

    // Uses the pre-advance LFSR value even when en_lfsr is high this cycle.
    assign load_value = CNT_W'(MIN_TICKS) + CNT_W'(lfsr);

    assign busy = (state == COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A tick coinciding with the start edge is not counted because the load
    // happens in IDLE. Dropping start_delay in COUNT aborts silently; in DONE
    // the level must drop before another delay can be armed.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        decrement  = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_rise) begin
                    load       = 1'b1;
                    next_state = COUNT;
                end
            end
            COUNT: begin
                if (!start_delay) begin
                    next_state = IDLE;
                end else if (tick) begin
                    if (cnt <= CNT_W'(1)) begin
                        expire     = 1'b1;
                        next_state = DONE;
                    end else begin
                        decrement = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!start_delay) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // time_out is registered from expire so it lines up with busy dropping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            cnt         <= '0;
            delay_ticks <= '0;
            time_out    <= 1'b0;
        end else begin
            start_q  <= start_delay;
            time_out <= expire;
            if (load) begin
                cnt         <= load_value;
                delay_ticks <= load_value;
            end else if (decrement) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_random_delay.sv
// tb_random_delay
// Self-checking bench for random_delay built with MIN_TICKS = 4.
module tb_random_delay;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        en_lfsr;
    logic        start_delay;
    logic        time_out;
    logic        busy;
    logic [15:0] delay_ticks;

    int checks;
    int errors;

    random_delay #(
        .LFSR_W    (7),
        .CNT_W     (16),
        .MIN_TICKS (4),
        .SEED      (7'h01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .en_lfsr     (en_lfsr),
        .start_delay (start_delay),
        .time_out    (time_out),
        .busy        (busy),
        .delay_ticks (delay_ticks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        sd;
        logic        tk;
        logic [6:0]  exp_lfsr;
        logic        exp_busy;
        logic        exp_to;
        logic [15:0] exp_dt;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [6:0] lfsrNext(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[2]};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive inputs for one clock and return #1 after the sampling edge.
    task automatic applyStimulus(input logic en, input logic sd, input logic tk);
        en_lfsr     = en;
        start_delay = sd;
        tick        = tk;
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int bad_steps;
    int zero_seen;
    logic [6:0] model;

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        tick        = 1'b0;
        en_lfsr     = 1'b0;
        start_delay = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 7'h02, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 7'h04, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 7'h09, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 7'h09, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 7'h09, 1'b1, 1'b0, 16'd13};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 7'h09, 1'b1, 1'b0, 16'd13};

        // Reset state, observed before any clock edge.
        #1;
        checkOutput("reset_lfsr", 16'(dut.lfsr), 16'h01);
        checkOutput("reset_busy", 16'(busy), 16'd0);
        checkOutput("reset_time_out", 16'(time_out), 16'd0);
        checkOutput("reset_delay_ticks", delay_ticks, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LFSR stepping and the first load from lfsr = 09.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].en, vecs[i].sd, vecs[i].tk);
            checkOutput($sformatf("vec%0d_lfsr", i), 16'(dut.lfsr), 16'(vecs[i].exp_lfsr));
            checkOutput($sformatf("vec%0d_busy", i), 16'(busy), 16'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_time_out", i), 16'(time_out), 16'(vecs[i].exp_to));
            checkOutput($sformatf("vec%0d_delay_ticks", i), delay_ticks, vecs[i].exp_dt);
        end

        // Basic delay: 12 ticks keep counting, the 13th fires.
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (time_out) pulses++;
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (time_out) pulses++;
        end
        checkOutput("basic_early_pulse", 16'(pulses), 16'd0);
        checkOutput("basic_busy_before", 16'(busy), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("basic_time_out", 16'(time_out), 16'd1);
        checkOutput("basic_busy_drop", 16'(busy), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("basic_pulse_width", 16'(time_out), 16'd0);

        // No retrigger while start_delay stays high.
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (time_out || busy) pulses++;
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (time_out || busy) pulses++;
        end
        checkOutput("retrigger_held", 16'(pulses), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("retrigger_busy", 16'(busy), 16'd1);
        checkOutput("retrigger_delay_ticks", delay_ticks, 16'd13);

        // Abort after 3 ticks.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        checkOutput("abort_busy_before", 16'(busy), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_busy", 16'(busy), 16'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (time_out) pulses++;
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (time_out) pulses++;
        end
        checkOutput("abort_no_pulse", 16'(pulses), 16'd0);
        checkOutput("abort_delay_ticks", delay_ticks, 16'd13);

        // Async reset at tick 5 of a fresh delay.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rst_run_busy", 16'(busy), 16'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
        tick = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_busy", 16'(busy), 16'd0);
        checkOutput("rst_async_delay_ticks", delay_ticks, 16'd0);
        checkOutput("rst_async_time_out", 16'(time_out), 16'd0);
        checkOutput("rst_async_lfsr", 16'(dut.lfsr), 16'h01);
        tick        = 1'b0;
        start_delay = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_hold_time_out", 16'(time_out), 16'd0);
        rst = 1'b0;

        // Tick coincident with the start edge; en_lfsr also high, so the
        // pre-advance value 02 is loaded: 4 + 2 = 6.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("simul_lfsr_pre", 16'(dut.lfsr), 16'h02);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("simul_delay_ticks", delay_ticks, 16'd6);
        checkOutput("simul_lfsr_post", 16'(dut.lfsr), 16'h04);
        checkOutput("simul_busy", 16'(busy), 16'd1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (time_out) pulses++;
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (time_out) pulses++;
        end
        checkOutput("simul_no_early", 16'(pulses), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("simul_time_out", 16'(time_out), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("simul_pulse_width", 16'(time_out), 16'd0);

        // Full LFSR period from reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        model     = 7'h01;
        bad_steps = 0;
        zero_seen = 0;
        for (int i = 0; i < 127; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            model = lfsrNext(model);
            if (dut.lfsr !== model) bad_steps++;
            if (dut.lfsr == 7'h00) zero_seen++;
        end
        checkOutput("period_bad_steps", 16'(bad_steps), 16'd0);
        checkOutput("period_zero", 16'(zero_seen), 16'd0);
        checkOutput("period_return", 16'(dut.lfsr), 16'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
